// File: rtl/stream_mux4.sv
// Four-channel valid/ready merger with a registered output and a 2-bit source tag.
// Define STREAM_MUX4_FIXED_PRIO_EN for fixed priority a > b > c > d instead of round-robin.
module stream_mux4 #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_c,
  input  logic [DW-1:0] in_d,
  input  logic          valid_a,
  input  logic          valid_b,
  input  logic          valid_c,
  input  logic          valid_d,
  output logic          ready_a,
  output logic          ready_b,
  output logic          ready_c,
  output logic          ready_d,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [3:0]    valid_vec;
  logic [3:0]    ready_vec;
  logic [1:0]    start_idx;
  logic [1:0]    grant_idx;
  logic          grant_any;
  logic          load_en;
  logic          transfer;
  logic [DW-1:0] grant_data;

`ifndef STREAM_MUX4_FIXED_PRIO_EN
  logic [1:0] last;
`endif

  assign valid_vec = {valid_d, valid_c, valid_b, valid_a};
  assign load_en   = !out_valid || out_ready;

`ifdef STREAM_MUX4_FIXED_PRIO_EN
  assign start_idx = 2'd0;
`else
  assign start_idx = last + 2'd1;
`endif

  // Cyclic search from start_idx; the 2-bit index wraps d->a on its own.
  always_comb begin
    logic [1:0] idx;
    grant_any = 1'b0;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = start_idx + 2'(i);
      if (!grant_any && valid_vec[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Hold ready low during reset so no source word is consumed while the output is cleared.
  always_comb begin
    ready_vec = 4'b0000;
    if (grant_any && load_en && rst_n) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  assign ready_a  = ready_vec[0];
  assign ready_b  = ready_vec[1];
  assign ready_c  = ready_vec[2];
  assign ready_d  = ready_vec[3];
  assign transfer = |(ready_vec & valid_vec);

  always_comb begin
    grant_data = '0;
    case (grant_idx)
      2'd0:    grant_data = in_a;
      2'd1:    grant_data = in_b;
      2'd2:    grant_data = in_c;
      default: grant_data = in_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifndef STREAM_MUX4_FIXED_PRIO_EN
  // Reset value 3 gives channel a first priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 2'd3;
    end else if (transfer) begin
      last <= grant_idx;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux4.sv
// Scoreboard bench for stream_mux4: a cycle model predicts ready/output, a queue checks words in order.
// Honours STREAM_MUX4_FIXED_PRIO_EN in its arbitration model.
module tb_stream_mux4;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_a, in_b, in_c, in_d;
  logic       valid_a, valid_b, valid_c, valid_d;
  logic       ready_a, ready_b, ready_c, ready_d;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;

  int nChecks = 0;
  int nFails  = 0;

  logic [5:0] sbQueue[$];

  logic       mValid;
  logic [3:0] mData;
  logic [1:0] mSel;
  logic [1:0] mLast;

  logic [3:0] rdyVec;
  assign rdyVec = {ready_d, ready_c, ready_b, ready_a};

  stream_mux4 #(.DW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .valid_a(valid_a), .valid_b(valid_b), .valid_c(valid_c), .valid_d(valid_d),
    .ready_a(ready_a), .ready_b(ready_b), .ready_c(ready_c), .ready_d(ready_d),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mValid = 1'b0;
    mData  = 4'h0;
    mSel   = 2'd0;
    mLast  = 2'd3;
    sbQueue.delete();
  endtask

  // Drive one cycle of stimulus at the falling edge, check against the model, advance the model.
  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] d, input logic ordy);
    logic       loadEn;
    logic       found;
    logic [1:0] startIdx;
    logic [1:0] idx;
    logic [1:0] gIdx;
    logic [3:0] expReady;
    logic [3:0] gData;
    logic [5:0] exp;
    {valid_d, valid_c, valid_b, valid_a} = v;
    {in_d, in_c, in_b, in_a} = d;
    out_ready = ordy;
    #1;
    loadEn = !mValid || ordy;
`ifdef STREAM_MUX4_FIXED_PRIO_EN
    startIdx = 2'd0;
`else
    startIdx = mLast + 2'd1;
`endif
    found = 1'b0;
    gIdx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = startIdx + 2'(i);
      if (!found && v[idx]) begin
        found = 1'b1;
        gIdx  = idx;
      end
    end
    expReady = (found && loadEn) ? (4'b0001 << gIdx) : 4'b0000;
    gData    = 4'((d >> (4 * int'(gIdx))) & 16'hF);

    checkOutput("ready", 32'(rdyVec), 32'(expReady));
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("out_data", 32'(out_data), 32'(mData));
    checkOutput("out_sel", 32'(out_sel), 32'(mSel));

    if (out_valid && ordy) begin
      checkOutput("sb_nonempty", 32'(sbQueue.size() != 0), 32'd1);
      if (sbQueue.size() != 0) begin
        exp = sbQueue.pop_front();
        checkOutput("sb_word", 32'({out_sel, out_data}), 32'(exp));
      end
    end

    if (expReady != 4'b0000) begin
      mValid = 1'b1;
      mData  = gData;
      mSel   = gIdx;
      mLast  = gIdx;
      sbQueue.push_back({gIdx, gData});
    end else if (mValid && ordy) begin
      mValid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_sel"}, 32'(out_sel), 32'd0);
    checkOutput({tag, "_ready"}, 32'(rdyVec), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    {valid_d, valid_c, valid_b, valid_a} = 4'hF;
    {in_d, in_c, in_b, in_a} = 16'h8421;
    out_ready = 1'b1;
    modelReset();
    #1;
    checkResetState("rst0");
    repeat (2) @(negedge clk);
    checkResetState("rst1");
    rst_n = 1'b1;

    $display("[TB] round-robin");
    repeat (6) applyStimulus(4'hF, 16'h8421, 1'b1);

    $display("[TB] skip and wrap");
    repeat (4) applyStimulus(4'b1010, 16'h8421, 1'b1);
    repeat (3) applyStimulus(4'b0010, 16'h8421, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(4'hF, 16'h8421, 1'b1);
    repeat (3) applyStimulus(4'hF, 16'h8421, 1'b0);
    repeat (3) applyStimulus(4'hF, 16'h8421, 1'b1);

    $display("[TB] drain to empty");
    repeat (2) applyStimulus(4'h0, 16'h0000, 1'b1);
    applyStimulus(4'b0100, 16'h0C00, 1'b1);
    repeat (3) applyStimulus(4'h0, 16'h0000, 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), 16'($urandom),
                    1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] mid-operation reset");
    repeat (3) applyStimulus(4'hF, 16'h5A3C, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midrst");
    modelReset();
    @(negedge clk);
    checkResetState("midrst_hold");
    rst_n = 1'b1;
    repeat (5) applyStimulus(4'hF, 16'h8421, 1'b1);

    repeat (3) applyStimulus(4'h0, 16'h0000, 1'b1);
    checkOutput("sb_leftover", 32'(sbQueue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
